// File: rtl/ahb_master_arbiter.sv
// Round-robin arbiter sharing one AHB master port among NUM_REQ requesters,
// with one outstanding read. Optional burst lock: define ARB_BURST_LOCK_EN.
module ahb_master_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int BURST_LEN = 4
) (
  input  logic                    ahbclk,
  input  logic                    ahbrst,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  input  logic [32*NUM_REQ-1:0]   i_req_addr,
  input  logic [32*NUM_REQ-1:0]   i_req_wr_data,
  input  logic [NUM_REQ-1:0]      i_req_rd0_wr1,
  output logic [NUM_REQ-1:0]      o_req_ready,
  output logic [NUM_REQ-1:0]      o_req_rd_valid,
  output logic [31:0]             o_req_rd_data,
  output logic [31:0]             o_addr,
  output logic [31:0]             o_wr_data,
  output logic                    o_rd0_wr1,
  output logic                    o_valid,
  input  logic                    i_ready,
  input  logic [31:0]             i_rd_data,
  input  logic                    i_rd_valid,
  output logic [1:0]              o_grant_id,
  output logic                    o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD
  } state_e;

  state_e        state_q;
  logic [1:0]    rr_ptr_q;
  logic [1:0]    grant_q;
  logic          valid_q;
  logic          rd0_wr1_q;
  logic [31:0]   addr_q;
  logic [31:0]   wr_data_q;

  logic               rr_found_d;
  logic [1:0]         rr_win_d;
  logic [1:0]         win_id_d;
  logic [NUM_REQ-1:0] win_oh_d;
  logic [NUM_REQ-1:0] grant_oh_d;
  logic               capture_d;
  logic               lock_d;

  // First asserted requester strictly after rr_ptr, wrapping around.
  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    rr_found_d = 1'b0;
    rr_win_d   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!rr_found_d && i_req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        rr_found_d = 1'b1;
        rr_win_d   = 2'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  assign grant_oh_d = NUM_REQ'(1) << grant_q;

`ifdef ARB_BURST_LOCK_EN
  logic [3:0] burst_cnt_q;
  logic       last_vld_q;

  // The first grant after reset has no previous winner to lock onto.
  assign lock_d = last_vld_q && (|(i_req_valid & grant_oh_d)) &&
                  (burst_cnt_q < 4'(BURST_LEN - 1));
`else
  assign lock_d = 1'b0;
`endif

  assign win_id_d  = lock_d ? grant_q : rr_win_d;
  assign win_oh_d  = NUM_REQ'(1) << win_id_d;
  assign capture_d = (state_q == IDLE) && (|i_req_valid);

  // Gated by reset so no ready pulse escapes while reset is held.
  assign o_req_ready    = win_oh_d & {NUM_REQ{capture_d & ahbrst}};
  assign o_req_rd_valid = grant_oh_d & {NUM_REQ{(state_q == WAIT_RD) & i_rd_valid}};
  assign o_req_rd_data  = i_rd_data;

  assign o_addr     = addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_rd0_wr1  = rd0_wr1_q;
  assign o_valid    = valid_q;
  assign o_grant_id = grant_q;
  assign o_busy     = (state_q != IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge ahbclk or negedge ahbrst) begin
    if (!ahbrst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 2'(NUM_REQ - 1);
      grant_q     <= '0;
      valid_q     <= 1'b0;
      rd0_wr1_q   <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
`ifdef ARB_BURST_LOCK_EN
      burst_cnt_q <= '0;
      last_vld_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (capture_d) begin
            addr_q    <= i_req_addr[32*int'(win_id_d) +: 32];
            wr_data_q <= i_req_wr_data[32*int'(win_id_d) +: 32];
            rd0_wr1_q <= |(i_req_rd0_wr1 & win_oh_d);
            rr_ptr_q  <= win_id_d;
            grant_q   <= win_id_d;
            valid_q   <= 1'b1;
            state_q   <= ISSUE;
`ifdef ARB_BURST_LOCK_EN
            burst_cnt_q <= lock_d ? burst_cnt_q + 4'd1 : 4'd0;
            last_vld_q  <= 1'b1;
`endif
          end
        end
        ISSUE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            state_q <= rd0_wr1_q ? IDLE : WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (i_rd_valid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ahb_master_arbiter.md
# ahb_master_arbiter

Round-robin arbiter that shares the single AHB-side master port (addr / wr_data / rd0_wr1 / valid / ready) of the SPI flash subsystem between several requesters: the SPI flash DMA engine, the register-file writeback path and future masters. It captures one request at a time into an output register, drives it until the bus accepts it, and for reads tracks a single outstanding transaction and routes the returned data to its issuer. It sits in the AHB clock domain, between the requesters and the AHB master bridge.

## Interface
- NUM_REQ, 2, number of requesters (2..4)
- BURST_LEN, 4, max consecutive grants to one requester when burst lock is compiled in (1..15)
- ahbclk  in  1  AHB clock; all logic on rising edge
- ahbrst  in  1  asynchronous, active-low reset
- i_req_valid  in  NUM_REQ  per-requester request valid
- i_req_addr  in  32*NUM_REQ  request address, requester n at [32n+31:32n]
- i_req_wr_data  in  32*NUM_REQ  write data, same packing
- i_req_rd0_wr1  in  NUM_REQ  0 = read, 1 = write
- o_req_ready  out  NUM_REQ  one-hot pulse: request captured this cycle
- o_req_rd_valid  out  NUM_REQ  one-hot: read data valid for requester n
- o_req_rd_data  out  32  read data, shared by all requesters
- o_addr / o_wr_data  out  32 / 32  registered bus request
- o_rd0_wr1  out  1  registered direction
- o_valid  out  1  bus request valid
- i_ready  in  1  bus accepts request when o_valid & i_ready
- i_rd_data  in  32  bus read data
- i_rd_valid  in  1  bus read data valid
- o_grant_id  out  2  index of current or last winner
- o_busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT_RD.
- IDLE: if any i_req_valid, choose winner g (round-robin: first asserted index after rr_ptr, wrapping); o_req_ready[g]=1 combinationally this cycle; capture addr/data/dir into output regs; rr_ptr<=g; o_grant_id<=g; -> ISSUE. No request: stay.
- ISSUE: o_valid=1, outputs stable. On i_ready: write -> IDLE; read -> WAIT_RD.
- WAIT_RD: o_valid=0. On i_rd_valid: o_req_rd_valid[g]=1 and o_req_rd_data=i_rd_data (combinational pass-through, same cycle); -> IDLE.
- i_rd_valid outside WAIT_RD is ignored. Only one read outstanding; no new capture until it returns.
- A requester must hold valid/addr/data stable until its o_req_ready pulse; deasserting before it withdraws the request without side effects.
- o_req_rd_data = i_rd_data at all times; only o_req_rd_valid qualifies it.
- rr_ptr reset value = NUM_REQ-1, so requester 0 has first priority.

## Timing
- Reset (async, immediate): state IDLE, o_valid 0, o_addr/o_wr_data 0, o_rd0_wr1 0, o_grant_id 0, o_busy 0, all o_req_ready/o_req_rd_valid 0, burst count 0. Reset mid-ISSUE drops the transfer; no ready/rd_valid is issued afterwards.
- Capture in cycle N -> o_valid high in N+1.
- Write accepted in cycle M -> IDLE in M+1 -> next capture M+1, o_valid M+2; max throughput 1 write / 2 cycles.
- Read: rd_valid in cycle K -> requester sees it in K, IDLE in K+1.
- i_ready held low: o_valid and payload held indefinitely.

## Configuration
- ARB_BURST_LOCK_EN defined: burst counter (4 bit). In IDLE, if last winner g still has i_req_valid and count < BURST_LEN-1, g wins regardless of rr_ptr and count increments; else round-robin and count <= 0. With BURST_LEN=1, behaviour equals the macro being absent.
- Undefined: pure round-robin every capture; no counter.

## Test plan
- Reset then single write from req0 (addr 0x1000, data 0xA5A5A5A5), i_ready tied 1 -> o_req_ready[0] in the capture cycle, o_valid one cycle later with those values, o_busy low again 2 cycles after capture.
- req0 and req1 both valid continuously with writes, i_ready=1, burst lock absent -> grants alternate 0,1,0,1; o_grant_id follows.
- Read from req1 (addr 0x2000), i_ready=1, i_rd_valid with 0xDEADBEEF 3 cycles later -> o_req_rd_valid=2'b10 same cycle with that data; req0 request pending meanwhile is not captured until the cycle after.
- i_ready held 0 for 5 cycles in ISSUE -> o_valid and o_addr stable throughout; a spurious i_rd_valid in ISSUE produces no o_req_rd_valid.
- ARB_BURST_LOCK_EN, BURST_LEN=4, req0 and req1 continuously valid -> grant pattern 0,0,0,0,1,1,1,1,0.
- Assert ahbrst mid-ISSUE -> o_valid 0 immediately; after release, requester 0 wins first.
